demux4_deser: RTL

- 1-to-4 deserializer: the receiving end of a 4:1 mux serializer that steps its select {s1,s0} through 0,1,2,3.
- Captures four consecutive accepted beats from a single serial lane into lanes w0..w3 and presents them as one parallel word.
- Uses a valid/ready handshake on both sides.
- Sits between a serial link/transfer path and parallel datapath logic, for example register-file or bus-width conversion.

---
 rtl/demux4_deser.sv | 116 +++++++++++
 1 files changed

// File: rtl/demux4_deser.sv
// demux4_deser: 1-to-4 deserializer with valid/ready handshakes on both sides.
// Collects four accepted serial beats (select order 00,01,10,11) and presents
// them as one registered parallel word on out_w0..out_w3. in_first resyncs the
// frame to beat 0; a resync that discards a partial frame pulses frame_err.
module demux4_deser #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_first,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_w0,
    output logic [WIDTH-1:0] out_w1,
    output logic [WIDTH-1:0] out_w2,
    output logic [WIDTH-1:0] out_w3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       slot,
    output logic             frame_err
);

    logic [1:0]       slot_r;
    logic [WIDTH-1:0] stage0_r;
    logic [WIDTH-1:0] stage1_r;
    logic [WIDTH-1:0] stage2_r;
    logic [WIDTH-1:0] w0_r;
    logic [WIDTH-1:0] w1_r;
    logic [WIDTH-1:0] w2_r;
    logic [WIDTH-1:0] w3_r;
    logic             out_valid_r;
    logic             frame_err_r;
    logic             in_ready_s;
    logic             accept_s;
    logic             transfer_s;

    // Ready: slots 0..2 only touch staging; slot 3 needs the output word free or leaving.
    always_comb begin
        in_ready_s = 1'b1;
        if (slot_r == 2'd3) begin
            in_ready_s = !out_valid_r || out_ready;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign accept_s   = in_valid && in_ready_s;
    assign transfer_s = out_valid_r && out_ready;

    // Beat capture, frame load, output handshake and resync error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_r      <= 2'd0;
            stage0_r    <= '0;
            stage1_r    <= '0;
            stage2_r    <= '0;
            w0_r        <= '0;
            w1_r        <= '0;
            w2_r        <= '0;
            w3_r        <= '0;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            // A transfer frees the word; a load below on the same edge re-asserts valid.
            if (transfer_s) begin
                out_valid_r <= 1'b0;
            end
            if (accept_s) begin
                if (in_first) begin
                    // Resync: this beat is beat 0 of a fresh frame, whatever was staged.
                    stage0_r    <= in_data;
                    slot_r      <= 2'd1;
                    frame_err_r <= (slot_r != 2'd0);
                end else begin
                    case (slot_r)
                        2'd0: begin
                            stage0_r <= in_data;
                            slot_r   <= 2'd1;
                        end
                        2'd1: begin
                            stage1_r <= in_data;
                            slot_r   <= 2'd2;
                        end
                        2'd2: begin
                            stage2_r <= in_data;
                            slot_r   <= 2'd3;
                        end
                        2'd3: begin
                            w0_r        <= stage0_r;
                            w1_r        <= stage1_r;
                            w2_r        <= stage2_r;
                            w3_r        <= in_data;
                            out_valid_r <= 1'b1;
                            slot_r      <= 2'd0;
                        end
                        default: begin
                            slot_r <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_w0    = w0_r;
    assign out_w1    = w1_r;
    assign out_w2    = w2_r;
    assign out_w3    = w3_r;
    assign out_valid = out_valid_r;
    assign slot      = slot_r;
    assign frame_err = frame_err_r;

endmodule
